// File: rtl/coin_acceptor_fsm.sv
// Coin acceptor / payment front-end for the change dispenser: accumulates credit and runs the money/price/start/done handshake.
// Optional refund path enabled by defining COIN_CANCEL_EN (adds the cancel input).
module coin_acceptor_fsm #(
  parameter int unsigned MAX_MONEY    = 100,
  parameter int unsigned START_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_Q,
  input  logic       coin_D,
  input  logic       coin_N,
  input  logic       coin_P,
  input  logic [6:0] sel_price,
  input  logic       buy,
  input  logic       done,
`ifdef COIN_CANCEL_EN
  input  logic       cancel,
`endif
  output logic [6:0] money,
  output logic [6:0] price,
  output logic       start,
  output logic       busy,
  output logic       coin_reject,
  output logic       insufficient
);

  localparam int unsigned CNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(START_CYCLES - 1);
  localparam logic [7:0] MAX_SUM = 8'(MAX_MONEY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       money_q, money_d;
  logic [6:0]       price_q, price_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             coin_reject_q, coin_reject_d;
  logic             insufficient_q, insufficient_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] n_coins;
  logic       any_coin;
  logic [7:0] coin_val;
  logic [7:0] coin_sum;
  logic       cancel_go;

  // Coin decode; the 8-bit sum cannot wrap so the ceiling compare is exact.
  always_comb begin
    n_coins  = 3'(coin_Q) + 3'(coin_D) + 3'(coin_N) + 3'(coin_P);
    any_coin = coin_Q | coin_D | coin_N | coin_P;
    coin_val = 8'd0;
    if (coin_Q)      coin_val = 8'd25;
    else if (coin_D) coin_val = 8'd10;
    else if (coin_N) coin_val = 8'd5;
    else if (coin_P) coin_val = 8'd1;
    coin_sum = {1'b0, money_q} + coin_val;
`ifdef COIN_CANCEL_EN
    cancel_go = cancel && (money_q != 7'd0);
`else
    cancel_go = 1'b0;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    money_d        = money_q;
    price_d        = price_q;
    start_d        = 1'b0;
    cnt_d          = cnt_q;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cancel_go) begin
          // Refund: dispenser returns the whole credit as change for a zero price.
          price_d       = 7'd0;
          state_d       = START;
          start_d       = 1'b1;
          cnt_d         = '0;
          coin_reject_d = any_coin;
        end else if (buy) begin
          if ((sel_price != 7'd0) && (money_q >= sel_price)) begin
            price_d = sel_price;
            state_d = START;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            insufficient_d = 1'b1;
          end
          coin_reject_d = any_coin;
        end else if (any_coin) begin
          if ((n_coins == 3'd1) && (coin_sum <= MAX_SUM)) begin
            money_d = coin_sum[6:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      START: begin
        coin_reject_d = any_coin;
        if (cnt_q == LAST_CNT) begin
          state_d = WAIT_DONE;
        end else begin
          start_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        coin_reject_d = any_coin;
        if (done) begin
          money_d = 7'd0;
          price_d = 7'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      money_q        <= 7'd0;
      price_q        <= 7'd0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      money_q        <= money_d;
      price_q        <= price_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      cnt_q          <= cnt_d;
    end
  end

  assign money        = money_q;
  assign price        = price_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;

endmodule

// File: tb/tb_coin_acceptor_fsm.sv
// Directed self-checking bench for coin_acceptor_fsm (default parameters; cancel cases when COIN_CANCEL_EN is defined).
module tb_coin_acceptor_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_Q, coin_D, coin_N, coin_P;
  logic [6:0] sel_price;
  logic       buy, done;
  logic [6:0] money, price;
  logic       start, busy, coin_reject, insufficient;
`ifdef COIN_CANCEL_EN
  logic       cancel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coin_acceptor_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .coin_Q       (coin_Q),
    .coin_D       (coin_D),
    .coin_N       (coin_N),
    .coin_P       (coin_P),
    .sel_price    (sel_price),
    .buy          (buy),
    .done         (done),
`ifdef COIN_CANCEL_EN
    .cancel       (cancel),
`endif
    .money        (money),
    .price        (price),
    .start        (start),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .insufficient (insufficient)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic q, input logic d, input logic n, input logic p);
    coin_Q = q; coin_D = d; coin_N = n; coin_P = p;
    step();
    coin_Q = 1'b0; coin_D = 1'b0; coin_N = 1'b0; coin_P = 1'b0;
  endtask

  task automatic do_buy(input logic [6:0] p);
    sel_price = p;
    buy       = 1'b1;
    step();
    buy       = 1'b0;
  endtask

  task automatic finish_txn(input string tag);
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq({tag, "_done_money"}, int'(money), 0);
    check_eq({tag, "_done_price"}, int'(price), 0);
    check_eq({tag, "_done_busy"},  int'(busy),  0);
  endtask

  initial begin
    reset = 1'b0;
    coin_Q = 1'b0; coin_D = 1'b0; coin_N = 1'b0; coin_P = 1'b0;
    sel_price = 7'd0; buy = 1'b0; done = 1'b0;
`ifdef COIN_CANCEL_EN
    cancel = 1'b0;
`endif
    step();
    step();
    check_eq("rst_money", int'(money), 0);
    check_eq("rst_price", int'(price), 0);
    check_eq("rst_start", int'(start), 0);
    check_eq("rst_busy",  int'(busy),  0);
    check_eq("rst_rej",   int'(coin_reject),  0);
    check_eq("rst_insuf", int'(insufficient), 0);
    reset = 1'b1;

    // 3 quarters, buy at 64: start held exactly two cycles.
    coin(1, 0, 0, 0); coin(1, 0, 0, 0); coin(1, 0, 0, 0);
    check_eq("t1_money75", int'(money), 75);
    do_buy(7'd64);
    check_eq("t1_start_c1", int'(start), 1);
    check_eq("t1_busy_c1",  int'(busy),  1);
    check_eq("t1_money_c1", int'(money), 75);
    check_eq("t1_price_c1", int'(price), 64);
    step();
    check_eq("t1_start_c2", int'(start), 1);
    step();
    check_eq("t1_start_c3", int'(start), 0);
    check_eq("t1_busy_wait", int'(busy), 1);
    check_eq("t1_money_wait", int'(money), 75);
    finish_txn("t1");

    // Fill to the ceiling, then a penny over it is refused.
    repeat (4) coin(1, 0, 0, 0);
    check_eq("t2_money100", int'(money), 100);
    coin(0, 0, 0, 1);
    check_eq("t2_reject", int'(coin_reject), 1);
    check_eq("t2_money_held", int'(money), 100);
    step();
    check_eq("t2_reject_pulse", int'(coin_reject), 0);
    do_buy(7'd54);
    check_eq("t2_start", int'(start), 1);
    check_eq("t2_money", int'(money), 100);
    check_eq("t2_price", int'(price), 54);
    step(); step();
    finish_txn("t2");

    // 55c short of 63: refused; zero price also refused; exact match accepted.
    coin(1, 0, 0, 0); coin(1, 0, 0, 0); coin(0, 0, 1, 0);
    check_eq("t3_money55", int'(money), 55);
    do_buy(7'd63);
    check_eq("t3_insuf", int'(insufficient), 1);
    check_eq("t3_nostart", int'(start), 0);
    check_eq("t3_nobusy",  int'(busy),  0);
    check_eq("t3_money_held", int'(money), 55);
    step();
    check_eq("t3_insuf_pulse", int'(insufficient), 0);
    do_buy(7'd0);
    check_eq("t3_zero_price", int'(insufficient), 1);
    coin(0, 1, 0, 0);
    check_eq("t3_money65", int'(money), 65);
    do_buy(7'd65);
    check_eq("t3_start", int'(start), 1);
    check_eq("t3_price", int'(price), 65);
    step(); step();
    finish_txn("t3");

    // Multi-coin reject, buy+coin, coin and buy while waiting.
    coin(0, 0, 1, 0);
    coin(0, 1, 1, 0);
    check_eq("t4_multi_rej", int'(coin_reject), 1);
    check_eq("t4_multi_money", int'(money), 5);
    sel_price = 7'd5; buy = 1'b1; coin_P = 1'b1;
    step();
    buy = 1'b0; coin_P = 1'b0;
    check_eq("t4_buycoin_rej", int'(coin_reject), 1);
    check_eq("t4_buycoin_money", int'(money), 5);
    check_eq("t4_buycoin_start", int'(start), 1);
    step(); step();
    coin(1, 0, 0, 0);
    check_eq("t4_wait_rej", int'(coin_reject), 1);
    check_eq("t4_wait_money", int'(money), 5);
    do_buy(7'd90);
    check_eq("t4_wait_buy_ign", int'(insufficient), 0);
    check_eq("t4_wait_busy", int'(busy), 1);
    finish_txn("t4");

    // Reset during START aborts the transaction; later done is ignored.
    coin(0, 1, 0, 0);
    do_buy(7'd10);
    check_eq("t5_start", int'(start), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("t5_rst_start", int'(start), 0);
    check_eq("t5_rst_money", int'(money), 0);
    check_eq("t5_rst_busy",  int'(busy),  0);
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq("t5_done_ign_busy",  int'(busy),  0);
    check_eq("t5_done_ign_start", int'(start), 0);
    coin(0, 0, 0, 1);
    check_eq("t5_idle_coin", int'(money), 1);

`ifdef COIN_CANCEL_EN
    // Refund via cancel, which outranks buy.
    coin(1, 0, 0, 0); coin(0, 0, 0, 1);
    check_eq("t6_money27", int'(money), 27);
    cancel = 1'b1; sel_price = 7'd20; buy = 1'b1;
    step();
    cancel = 1'b0; buy = 1'b0;
    check_eq("t6_start", int'(start), 1);
    check_eq("t6_money", int'(money), 27);
    check_eq("t6_price", int'(price), 0);
    step(); step();
    finish_txn("t6");
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check_eq("t6_cancel_zero", int'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
